// File: rtl/exu_result_stage.sv
// exu_result_stage: EX result select, RV64 div/rem fixups, W sign-extension, 2-entry skid buffer into WB
module exu_result_stage #(
  parameter int XLEN = 64,
  parameter int RW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            is_word,
  input  logic [RW-1:0]   rd,
  input  logic            rd_wen,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] r_add,
  input  logic [XLEN-1:0] r_sltu,
  input  logic [XLEN-1:0] r_srl,
  input  logic [XLEN-1:0] r_sra,
  input  logic [XLEN-1:0] r_sll,
  input  logic [XLEN-1:0] r_and,
  input  logic [XLEN-1:0] r_or,
  input  logic [XLEN-1:0] r_xor,
  input  logic [XLEN-1:0] r_mul,
  input  logic [XLEN-1:0] r_divu,
  input  logic [XLEN-1:0] r_div,
  input  logic [XLEN-1:0] r_remu,
  input  logic [XLEN-1:0] r_rem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [RW-1:0]   out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_pc
);
  localparam int BW = 2 * XLEN + RW + 1;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [BW-1:0] main_q, skid_q, beat;
  logic [XLEN-1:0] sel, fix;
  logic bz, ovf, in_fire, out_fire;
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign {out_res, out_rd, out_wen, out_pc} = main_q;
  always_comb begin
    case (op)
      4'd0:    sel = r_add;
      4'd1:    sel = r_sltu;
      4'd2:    sel = r_srl;
      4'd3:    sel = r_sra;
      4'd4:    sel = r_sll;
      4'd5:    sel = r_and;
      4'd6:    sel = r_or;
      4'd7:    sel = r_xor;
      4'd8:    sel = r_mul;
      4'd9:    sel = r_divu;
      4'd10:   sel = r_div;
      4'd11:   sel = r_remu;
      4'd12:   sel = r_rem;
      4'd13:   sel = src_b;
      default: sel = '0;
    endcase
    bz = is_word ? src_b[31:0] == 32'd0 : src_b == '0;
    ovf = is_word ? src_a[31:0] == 32'h8000_0000 && &src_b[31:0]
                  : src_a == {1'b1, {(XLEN-1){1'b0}}} && &src_b;
    // overflowing DIV returns MIN_INT, which is exactly src_a in the operand width
    fix = ((op == 4'd9 || op == 4'd10) && bz) ? '1 :
          ((op == 4'd11 || op == 4'd12) && bz) ? src_a :
          (op == 4'd10 && ovf) ? src_a :
          (op == 4'd12 && ovf) ? '0 : sel;
    beat = {is_word ? {{(XLEN-32){fix[31]}}, fix[31:0]} : fix, rd, rd_wen && rd != '0, pc};
  end
  always_comb begin
    state_nx = state;
    state_nx = state == EMPTY ? (in_fire ? ONE : EMPTY) :
               state == ONE ? ((in_fire && !out_fire) ? TWO : (out_fire && !in_fire) ? EMPTY : ONE) :
               (out_fire ? ONE : TWO);
  end
  always_ff @(posedge clk)
    if (rst) state <= EMPTY;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (state == TWO && out_fire) main_q <= skid_q;
      else if (in_fire && (state == EMPTY || out_fire)) main_q <= beat;
      if (state == ONE && in_fire && !out_fire) skid_q <= beat;
    end
endmodule

// File: tb/tb_exu_result_stage.sv
// tb_exu_result_stage: directed vectors, skid corner sequences and randomized scoreboard run
module tb_exu_result_stage;
  logic clk = 0, rst, in_valid, in_ready, is_word, rd_wen, out_valid, out_ready, out_wen;
  logic [3:0] op;
  logic [4:0] rd, out_rd;
  logic [63:0] pc, src_a, src_b, out_res, out_pc;
  logic [63:0] r [13];
  int tests = 0, fails = 0;
  typedef struct {
    logic [3:0] op; logic w; logic [63:0] a, b, alu; logic [4:0] rd; logic rw; logic [63:0] er; logic ew;
  } vec_t;
  typedef struct packed {logic [63:0] res; logic [4:0] rd; logic wen; logic [63:0] pc;} beat_t;
  vec_t v[$];
  beat_t q[$], e, nxt;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  exu_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .is_word(is_word),
    .rd(rd), .rd_wen(rd_wen), .pc(pc), .src_a(src_a), .src_b(src_b),
    .r_add(r[0]), .r_sltu(r[1]), .r_srl(r[2]), .r_sra(r[3]), .r_sll(r[4]), .r_and(r[5]), .r_or(r[6]),
    .r_xor(r[7]), .r_mul(r[8]), .r_divu(r[9]), .r_div(r[10]), .r_remu(r[11]), .r_rem(r[12]),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_rd(out_rd),
    .out_wen(out_wen), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // reference: RISC-V result rules stated on the selected ALU value
  function automatic logic [63:0] model(logic [3:0] o, logic w, logic [63:0] a, logic [63:0] b);
    logic [63:0] x;
    logic z, ov;
    z = w ? (b[31:0] == 0) : (b == 0);
    ov = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN && b == ONES);
    x = o <= 12 ? r[o] : o == 13 ? b : 64'd0;
    if ((o == 9 || o == 10) && z) x = ONES;
    else if ((o == 11 || o == 12) && z) x = a;
    else if (o == 10 && ov) x = w ? 64'h8000_0000 : MIN;
    else if (o == 12 && ov) x = 0;
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

  task automatic set_in(logic [3:0] o, logic w, logic [63:0] a, logic [63:0] b, logic [63:0] alu,
                        logic [4:0] d, logic dw, logic [63:0] p);
    for (int i = 0; i < 13; i++) r[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
    if (o < 13) r[o] = alu;
    op = o; is_word = w; src_a = a; src_b = b; rd = d; rd_wen = dw; pc = p;
  endtask

  task automatic rand_in();
    logic [63:0] a, b;
    case ($urandom_range(0, 3))
      0: a = MIN;
      1: a = {$urandom, 32'h8000_0000};
      default: a = {$urandom, $urandom};
    endcase
    case ($urandom_range(0, 5))
      0: b = 0;
      1: b = ONES;
      2: b = {$urandom, 32'h0};
      3: b = {$urandom, 32'hFFFF_FFFF};
      default: b = {$urandom, $urandom};
    endcase
    op = 4'($urandom_range(0, 15)); is_word = 1'($urandom); src_a = a; src_b = b;
    rd = 5'($urandom); rd_wen = 1'($urandom); pc = {$urandom, $urandom};
    for (int i = 0; i < 13; i++) r[i] = {$urandom, $urandom};
    nxt = '{model(op, is_word, a, b), rd, rd_wen && rd != 0, pc};
  endtask

  initial begin
    rst = 1; in_valid = 1; out_ready = 0;
    set_in(0, 0, 5, 7, 12, 1, 1, 64'h55);
    repeat (2) @(negedge clk);
    rst = 0; in_valid = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_pc", out_pc, 0);

    v.push_back('{0, 0, 5, 7, 12, 0, 1, 12, 0});
    v.push_back('{9, 0, 9, 0, 3, 3, 1, ONES, 1});
    v.push_back('{12, 0, MIN, ONES, 5, 4, 1, 0, 1});
    v.push_back('{10, 0, MIN, ONES, 5, 4, 1, MIN, 1});
    v.push_back('{0, 1, 64'h7FFF_FFFF, 1, 64'h8000_0000, 5, 1, 64'hFFFF_FFFF_8000_0000, 1});
    v.push_back('{10, 1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 6, 1, 64'hFFFF_FFFF_8000_0000, 1});
    v.push_back('{11, 0, 64'h1234, 0, 9, 7, 1, 64'h1234, 1});
    v.push_back('{12, 1, 64'h1_8000_0005, 64'h1_0000_0000, 9, 8, 1, 64'hFFFF_FFFF_8000_0005, 1});
    v.push_back('{13, 0, 1, 64'hABC, 9, 9, 1, 64'hABC, 1});
    v.push_back('{14, 0, 1, 2, 9, 10, 1, 0, 1});
    v.push_back('{15, 1, 1, 2, 9, 10, 1, 0, 1});
    v.push_back('{3, 0, 1, 2, 64'hF000_0000_0000_0001, 11, 1, 64'hF000_0000_0000_0001, 1});
    v.push_back('{10, 0, MIN, 64'hFFFF_FFFF, 7, 12, 1, 7, 1});
    v.push_back('{8, 1, 1, 2, 64'h1_7FFF_FFFF, 31, 0, 64'h7FFF_FFFF, 0});
    v.push_back('{1, 0, 1, 2, 1, 2, 1, 1, 1});
    v.push_back('{9, 1, 3, 64'h5_0000_0000, 4, 2, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    out_ready = 1;
    foreach (v[i]) begin
      set_in(v[i].op, v[i].w, v[i].a, v[i].b, v[i].alu, v[i].rd, v[i].rw, 64'(i));
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_res", i), out_res, v[i].er);
      chk($sformatf("vec%0d_wen", i), out_wen, v[i].ew);
      chk($sformatf("vec%0d_rd", i), out_rd, v[i].rd);
      chk($sformatf("vec%0d_pc", i), out_pc, 64'(i));
    end

    rst = 1; @(negedge clk); rst = 0;
    out_ready = 0;
    set_in(0, 0, 0, 0, 64'hA, 1, 1, 1); in_valid = 1;
    @(negedge clk);
    chk("bp_ready_a", in_ready, 1);
    set_in(0, 0, 0, 0, 64'hB, 2, 1, 2);
    @(negedge clk);
    chk("bp_full", in_ready, 0);
    set_in(0, 0, 0, 0, 64'hC, 3, 1, 3);
    @(negedge clk);
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_res", out_res, 64'hA);
    out_ready = 1;
    @(negedge clk);
    chk("bp_b", out_res, 64'hB);
    chk("bp_ready_c", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    chk("bp_c", out_res, 64'hC);
    chk("bp_c_valid", out_valid, 1);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    set_in(0, 0, 0, 0, 64'd100, 4, 1, 0); in_valid = 1;
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      set_in(0, 0, 0, 0, 64'(100 + k), 4, 1, 64'(k));
      chk("thr_valid", out_valid, 1);
      chk("thr_ready", in_ready, 1);
      chk("thr_res", out_res, 64'(100 + k - 1));
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0; in_valid = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_res", out_res, 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rand_in();
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      chk("rnd_out_valid", out_valid, q.size() > 0);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rnd_res", out_res, e.res);
        chk("rnd_rd", out_rd, e.rd);
        chk("rnd_wen", out_wen, e.wen);
        chk("rnd_pc", out_pc, e.pc);
      end
      if (in_valid && in_ready) q.push_back(nxt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
